inc_node_multi: RTL and testbench
=================================

Name: inc_node_multi

Overview:
- Parametrised bus demo application node; successor to the single-byte increment node.
- Receives words on its slave write port and buffers them in a small FIFO.
- Displays each word in hex on NUM_DIGITS seven-segment digits, applies a selectable arithmetic operation after a programmable delay, then forwards the result through its master port.
- Adds operation select, input buffering, transmit timeout and status flags, none of which the previous generation had.

Parameters:
- DATA_W, 8, data word width; must be a multiple of 4; NUM_DIGITS = DATA_W/4 (localparam).
- FIFO_DEPTH, 4, receive FIFO entries; power of two, ≥2.
- DELAY_CYCLES, 22, display dwell before the operation is applied.
- STEP, 1, addend for op_sel=2'b10, taken modulo 2^DATA_W.
- TX_TIMEOUT, 1023, cycles to wait for m_tx_done; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mode_switch  in  1  node enable; 0 = ignore slave writes and button.
- button  in  1  level input, already synchronised; rising edge = local send request.
- op_sel  in  2  operation: 00 +1, 01 −1, 10 +STEP, 11 pass-through.
- sw_array_data  in  DATA_W  local switch data.
- s_data  in  DATA_W  slave write data.
- s_write_en_in  in  1  slave write strobe; one word per high cycle.
- m_tx_done  in  1  master transfer complete.
- m_data_out  out  DATA_W  master write data.
- m_instruction  out  2  00 idle, 10 write request.
- display_pins  out  7*NUM_DIGITS  segments, active-low {g,f,e,d,c,b,a}; digit k shows nibble k of disp_reg.
- busy  out  1  high in any state other than IDLE.
- fifo_full  out  1  FIFO count == FIFO_DEPTH.
- overflow  out  1  sticky; a slave write was dropped.
- tx_timeout  out  1  sticky; a transfer was abandoned.

Behaviour:
- Reset values: disp_reg, m_data_out, m_instruction, flags and FIFO count all 0; state IDLE; button edge detector primed with button=0. display_pins therefore shows all digits "0".
- FIFO push: s_write_en_in=1 and mode_switch=1.
  - Accepted if count<FIFO_DEPTH, or if a pop happens the same cycle (count is then unchanged).
  - Otherwise the word is dropped and overflow is set; overflow clears only on reset.
- Button: a rising edge while mode_switch=1 sets a single pending flag. Further edges while the flag is set are discarded. The flag clears when IDLE accepts the request.
- State IDLE (m_instruction=00):
  - If the FIFO is non-empty: pop the head into disp_reg, clear delay_cnt, go to DELAY. The FIFO has priority over the button.
  - Else if the button flag is pending: disp_reg <= sw_array_data, go to SEND. No operation is applied.
- State DELAY:
  - delay_cnt increments each cycle.
  - When delay_cnt==DELAY_CYCLES: disp_reg <= op(disp_reg) and go to SEND. This makes DELAY_CYCLES+1 cycles in DELAY.
  - op_sel is sampled on this update cycle.
  - Arithmetic is modulo 2^DATA_W: FF+1→00, 00−1→FF.
- State SEND:
  - Every cycle: m_data_out <= disp_reg, m_instruction <= 10, tx_cnt increments.
  - m_tx_done=1: m_instruction <= 00, go to IDLE. m_data_out holds its last value.
  - Timeout (TX_TIMEOUT≠0 and tx_cnt==TX_TIMEOUT, done not seen): m_instruction <= 00, tx_timeout <= 1, go to IDLE. The word is discarded.
- mode_switch=0 mid-operation: the current DELAY/SEND completes normally. FIFO contents are retained and are still drained from IDLE.
- Latency: a slave write into an empty FIFO while IDLE gives m_instruction=10 on cycle push+DELAY_CYCLES+4. The cycles are push, pop/IDLE, DELAY_CYCLES+1 in DELAY, then the registered SEND output.
- Reset at any point returns to the reset values immediately. In-flight and buffered data are lost.
- Unused state encodings go to IDLE with m_instruction=00.

Test Plan:
- DATA_W=8, op_sel=00, mode_switch=1, slave write 0x3F:
  - display reads "3F" during DELAY, then "40".
  - m_instruction=10 with m_data_out=0x40 on the computed latency cycle.
  - Pulse m_tx_done → 00, IDLE.
- op_sel=01 with write 0x00 → output 0xFF. op_sel=10 with STEP=5 and write 0xFE → output 0x03. op_sel=11 with write 0xA5 → output 0xA5.
- Hold m_tx_done=0, issue 6 back-to-back writes 0x10..0x15 (FIFO_DEPTH=4):
  - fifo_full asserts.
  - overflow=1 after the words that do not fit are dropped.
  - Releasing m_tx_done drains the remaining words in order, each +1.
- m_tx_done never asserted, TX_TIMEOUT=1023 → tx_timeout=1 and m_instruction=00 exactly 1023 cycles after entering SEND; the next FIFO word is then processed.
- sw_array_data=0x5A, button edge while FIFO empty → output 0x5A with no delay and no op. Button edge while mode_switch=0 → no request. Simultaneous button edge and slave write → FIFO word is sent first, then 0x5A.
- Assert reset during DELAY and again during SEND → all outputs return to 0 and state returns to IDLE asynchronously; FIFO empty; flags cleared.

Source files
------------

// File: rtl/inc_node_multi_if.sv
// inc_node_multi_if: slave write port and master transfer port of the increment node.
interface inc_node_multi_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] s_data;
  logic              s_write_en_in;
  logic              m_tx_done;
  logic [DATA_W-1:0] m_data_out;
  logic [1:0]        m_instruction;
  modport master (input s_data, s_write_en_in, m_tx_done, output m_data_out, m_instruction);
  modport slave (output s_data, s_write_en_in, m_tx_done, input m_data_out, m_instruction);
endinterface

// File: rtl/inc_node_multi.sv
// inc_node_multi: buffers bus words, shows them in hex, applies an op after a dwell and forwards them.
module inc_node_multi #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DELAY_CYCLES = 22,
  parameter int STEP         = 1,
  parameter int TX_TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mode_switch,
  input  logic                         button,
  input  logic [1:0]                   op_sel,
  input  logic [DATA_W-1:0]            sw_array_data,
  inc_node_multi_if.master             bus,
  output logic [7*(DATA_W/4)-1:0]      display_pins,
  output logic                         busy,
  output logic                         fifo_full,
  output logic                         overflow,
  output logic                         tx_timeout
);
  localparam int ND = DATA_W / 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DELAY_CYCLES + 2);
  localparam int TW = $clog2(TX_TIMEOUT + 2);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [1:0] {IDLE, DELAY, SEND} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] disp_q, disp_d, data_q, data_d;
  logic [DW-1:0]     delay_q, delay_d;
  logic [TW-1:0]     tx_q, tx_d;
  logic [1:0]        instr_q, instr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic              ovf_q, ovf_d, tmo_q, tmo_d, pend_q, pend_d, btn_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              pop, push, push_req, accept;
  function automatic logic [DATA_W-1:0] apply_op(input logic [1:0] op, input logic [DATA_W-1:0] v);
    return op == 2'b00 ? v + DATA_W'(1) : op == 2'b01 ? v - DATA_W'(1) :
           op == 2'b10 ? v + DATA_W'(STEP) : v;
  endfunction
  assign pop      = state_q == IDLE && cnt_q != '0;
  assign accept   = state_q == IDLE && cnt_q == '0 && pend_q;
  assign push_req = bus.s_write_en_in && mode_switch;
  // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
  assign push     = push_req && (cnt_q != CW'(FIFO_DEPTH) || pop);
  always_comb begin
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    ovf_d   = ovf_q | (push_req & ~push);
    pend_d  = pend_q ? ~accept : button & ~btn_q & mode_switch;
    state_d = state_q;
    disp_d  = disp_q;
    delay_d = delay_q;
    tx_d    = tx_q;
    data_d  = data_q;
    instr_d = 2'b00;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          disp_d  = mem_q[rd_q];
          delay_d = '0;
          state_d = DELAY;
        end else if (accept) begin
          disp_d  = sw_array_data;
          tx_d    = '0;
          state_d = SEND;
        end
      end
      DELAY: begin
        delay_d = delay_q + DW'(1);
        if (delay_q == DW'(DELAY_CYCLES)) begin
          disp_d  = apply_op(op_sel, disp_q);
          tx_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        data_d = disp_q;
        tx_d   = tx_q + TW'(1);
        if (bus.m_tx_done) state_d = IDLE;
        else if (TX_TIMEOUT != 0 && tx_q == TW'(TX_TIMEOUT)) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else instr_d = 2'b10;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      disp_q  <= '0;
      data_q  <= '0;
      delay_q <= '0;
      tx_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      pend_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      data_q  <= data_d;
      delay_q <= delay_d;
      tx_q    <= tx_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      btn_q   <= button;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.s_data;
  end
  for (genvar k = 0; k < ND; k++) begin : g_dig
    assign display_pins[7*k +: 7] = SEG[disp_q[4*k +: 4]];
  end
  assign bus.m_data_out    = data_q;
  assign bus.m_instruction = instr_q;
  assign busy              = state_q != IDLE;
  assign fifo_full         = cnt_q == CW'(FIFO_DEPTH);
  assign overflow          = ovf_q;
  assign tx_timeout        = tmo_q;
endmodule

// File: tb/tb_inc_node_multi.sv
// tb_inc_node_multi: vector table, random scoreboard and corner sequences for inc_node_multi.
module tb_inc_node_multi;
  localparam int W = 8, D = 22, T = 1023, STEP = 5;
  localparam logic [13:0] ZERO = {7'h40, 7'h40};
  typedef struct {logic [1:0] op; logic [7:0] din; logic [7:0] exp;} vec_t;
  logic clk = 0, reset = 1, mode_switch = 1, button = 0;
  logic [1:0] op_sel = 0;
  logic [W-1:0] sw = 0;
  logic [13:0] display_pins;
  logic busy, fifo_full, overflow, tx_timeout, any_busy;
  int tests = 0, fails = 0, hi, n, op;
  logic [7:0] d;
  logic [7:0] q[$];
  vec_t tbl[8];
  inc_node_multi_if #(.DATA_W(W)) bus();
  inc_node_multi #(.DATA_W(W), .FIFO_DEPTH(4), .DELAY_CYCLES(D), .STEP(STEP), .TX_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .mode_switch(mode_switch), .button(button), .op_sel(op_sel),
    .sw_array_data(sw), .bus(bus), .display_pins(display_pins), .busy(busy),
    .fifo_full(fifo_full), .overflow(overflow), .tx_timeout(tx_timeout));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] v);
    bus.s_data = v;
    bus.s_write_en_in = 1;
    tick();
    bus.s_write_en_in = 0;
  endtask
  task automatic wait_req(input string name);
    int i = 0;
    while (bus.m_instruction !== 2'b10 && i < 300) begin
      tick();
      i++;
    end
    chk({name, " req"}, 32'(bus.m_instruction), 32'h2);
  endtask
  task automatic xfer(input string name, input logic [7:0] exp, input int gap);
    wait_req(name);
    if (bus.m_instruction === 2'b10) begin
      chk(name, 32'(bus.m_data_out), 32'(exp));
      repeat (gap) tick();
      bus.m_tx_done = 1;
      tick();
      bus.m_tx_done = 0;
      chk({name, " ack"}, 32'(bus.m_instruction), 32'h0);
    end
  endtask
  task automatic quiet(input string name);
    any_busy = 0;
    repeat (40) begin
      tick();
      any_busy |= busy | (bus.m_instruction != 2'b00);
    end
    chk(name, 32'(any_busy), 32'h0);
  endtask
  function automatic logic [7:0] ref_op(input int o, input logic [7:0] v);
    int r;
    r = o == 0 ? int'(v) + 1 : o == 1 ? int'(v) + 255 : o == 2 ? int'(v) + STEP : int'(v);
    return 8'(r % 256);
  endfunction

  initial begin
    tbl[0] = '{2'b00, 8'h3F, 8'h40};
    tbl[1] = '{2'b01, 8'h00, 8'hFF};
    tbl[2] = '{2'b10, 8'hFE, 8'h03};
    tbl[3] = '{2'b11, 8'hA5, 8'hA5};
    tbl[4] = '{2'b00, 8'hFF, 8'h00};
    tbl[5] = '{2'b01, 8'h80, 8'h7F};
    tbl[6] = '{2'b10, 8'hFB, 8'h00};
    tbl[7] = '{2'b11, 8'h00, 8'h00};
    bus.s_data = 0;
    bus.s_write_en_in = 0;
    bus.m_tx_done = 0;
    repeat (2) tick();
    chk("rst instr", 32'(bus.m_instruction), 0);
    chk("rst data", 32'(bus.m_data_out), 0);
    chk("rst display", 32'(display_pins), 32'(ZERO));
    reset = 0;
    tick();
    chk("rst flags", {busy, fifo_full, overflow, tx_timeout}, 0);
    // latency and display sequence for one word
    bus.s_data = 8'h3F;
    bus.s_write_en_in = 1;
    for (int k = 1; k <= D + 4; k++) begin
      tick();
      bus.s_write_en_in = 0;
      if (k == 2 || k == D + 2) chk("disp 3F", 32'(display_pins), 32'({7'h30, 7'h0E}));
      if (k == D + 3) begin
        chk("disp 40", 32'(display_pins), 32'({7'h19, 7'h40}));
        chk("lat early", 32'(bus.m_instruction), 0);
      end
    end
    chk("lat instr", 32'(bus.m_instruction), 2);
    xfer("lat", 8'h40, 0);
    chk("lat idle", 32'(busy), 0);
    foreach (tbl[i]) begin
      op_sel = tbl[i].op;
      wr(tbl[i].din);
      xfer($sformatf("vec%0d", i), tbl[i].exp, i % 3);
    end
    for (int b = 0; b < 20; b++) begin
      op = int'($urandom_range(0, 3));
      op_sel = 2'(op);
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        q.push_back(ref_op(op, d));
        wr(d);
        repeat ($urandom_range(0, 2)) tick();
      end
      while (q.size() > 0) xfer("rand", q.pop_front(), int'($urandom_range(0, 4)));
    end
    chk("rand ovf", 32'(overflow), 0);
    op_sel = 2'b00;
    for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    chk("ovf full", 32'(fifo_full), 1);
    chk("ovf flag", 32'(overflow), 1);
    for (int i = 0; i < 5; i++) xfer("drain", 8'h11 + 8'(i), 3);
    chk("drain empty", 32'(fifo_full), 0);
    wr(8'h20);
    wr(8'h70);
    wait_req("tmo");
    hi = 0;
    while (bus.m_instruction === 2'b10 && hi < 1100) begin
      hi++;
      tick();
    end
    chk("tmo len", 32'(hi), 32'(T));
    chk("tmo flag", 32'(tx_timeout), 1);
    xfer("tmo next", 8'h71, 0);
    sw = 8'h5A;
    button = 1;
    repeat (2) tick();
    chk("btn early", 32'(bus.m_instruction), 0);
    tick();
    chk("btn instr", 32'(bus.m_instruction), 2);
    xfer("btn", 8'h5A, 0);
    button = 0;
    tick();
    mode_switch = 0;
    button = 1;
    quiet("btn off");
    mode_switch = 1;
    quiet("btn held");
    button = 0;
    tick();
    bus.s_data = 8'h30;
    bus.s_write_en_in = 1;
    button = 1;
    tick();
    bus.s_write_en_in = 0;
    xfer("sim fifo", 8'h31, 1);
    xfer("sim btn", 8'h5A, 1);
    button = 0;
    wr(8'h44);
    wr(8'h45);
    wr(8'h46);
    repeat (5) tick();
    chk("pre rst busy", 32'(busy), 1);
    #2 reset = 1;
    #1;
    chk("rstD data", 32'(bus.m_data_out), 0);
    chk("rstD display", 32'(display_pins), 32'(ZERO));
    chk("rstD flags", {busy, fifo_full, overflow, tx_timeout}, 0);
    tick();
    reset = 0;
    quiet("rstD fifo");
    wr(8'h60);
    wait_req("rstS");
    #2 reset = 1;
    #1;
    chk("rstS instr", 32'(bus.m_instruction), 0);
    chk("rstS data", 32'(bus.m_data_out), 0);
    chk("rstS display", 32'(display_pins), 32'(ZERO));
    chk("rstS busy", 32'(busy), 0);
    tick();
    reset = 0;
    quiet("rstS idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
